// File: rtl/prog_loader_pkg.sv
// Shared types and defaults for the boot-time program loader.
package prog_loader_pkg;

  // Loader states, 3-bit encodings
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEN0  = 3'd1,
    ST_LEN1  = 3'd2,
    ST_DATA  = 3'd3,
    ST_CSUM  = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } ldr_state_e;

  localparam int unsigned LDR_MAX_WORDS = 1024;
  localparam int unsigned LDR_ADDR_W    = 32;

  // States in which the loader is willing to take a stream byte
  function automatic logic ldr_takes_bytes(input ldr_state_e s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Assembles four stream bytes, LSB first, into one 32-bit word.
// o_word/o_word_valid are combinational so the caller can register the
// completed word on the same edge that accepts its fourth byte.
module prog_loader_byte_packer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clear,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [1:0]  r_idx;
  logic [31:0] r_shift;

  // Shift bytes in from the top; index wraps 3 -> 0 after each full word
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (i_clear) begin
      r_idx   <= '0;
      r_shift <= '0;
    end else if (i_byte_en) begin
      r_idx   <= r_idx + 2'd1;
      r_shift <= {i_byte, r_shift[31:8]};
    end
  end

  assign o_word       = {i_byte, r_shift[31:8]};
  assign o_word_valid = i_byte_en && !i_clear && (r_idx == 2'd3);

endmodule

// File: rtl/prog_loader.sv
// Boot-time program loader: parses a length-prefixed byte stream, writes
// words into program memory and releases the core once the XOR checksum
// matches.
//
//  state    | meaning
//  ---------+-------------------------------------------------
//  IDLE     | after reset, waiting for start
//  LEN0     | expecting word count low byte
//  LEN1     | expecting word count high byte, range check
//  DATA     | packing payload bytes, one write per 4 bytes
//  CSUM     | expecting checksum byte
//  DONE     | image good, core released
//  ERROR    | length or checksum fault, core held in reset
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = LDR_MAX_WORDS,
  parameter int unsigned ADDR_W    = LDR_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_s_data,
  input  logic              i_s_valid,
  output logic              o_s_ready,
  output logic              o_prog_we,
  output logic [ADDR_W-1:0] o_prog_addr,
  output logic [31:0]       o_prog_wdata,
  output logic              o_core_rst_n,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [15:0] LP_MAX = 16'(MAX_WORDS);

  ldr_state_e        r_state;
  ldr_state_e        w_next;
  logic              w_ready;
  logic              w_hs;
  logic [15:0]       w_len_full;
  logic [31:0]       w_word;
  logic              w_word_valid;
  logic              w_pack_en;

  logic [15:0]       r_len;
  logic [15:0]       r_wcnt;
  logic [7:0]        r_csum;
  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_we;
  logic              r_done;
  logic              r_error;
  logic              r_core_rst_n;

  assign w_pack_en = w_hs && (r_state == ST_DATA);

  prog_loader_byte_packer u_packer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clear      (i_start),
    .i_byte_en    (w_pack_en),
    .i_byte       (i_s_data),
    .o_word       (w_word),
    .o_word_valid (w_word_valid)
  );

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // Next-state and handshake; start overrides everything and blocks the byte
  always_comb begin
    w_next     = r_state;
    w_ready    = ldr_takes_bytes(r_state) && !i_start;
    w_hs       = w_ready && i_s_valid;
    w_len_full = {i_s_data, r_len[7:0]};
    if (i_start) begin
      w_next = ST_LEN0;
    end else begin
      case (r_state)
        ST_IDLE:  w_next = ST_IDLE;
        ST_LEN0:  if (w_hs) w_next = ST_LEN1;
        ST_LEN1: begin
          if (w_hs) begin
            if (w_len_full == 16'd0)     w_next = ST_CSUM;
            else if (w_len_full > LP_MAX) w_next = ST_ERROR;
            else                          w_next = ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs && w_word_valid && ((r_wcnt + 16'd1) == r_len)) w_next = ST_CSUM;
        end
        ST_CSUM: begin
          if (w_hs) w_next = (i_s_data == r_csum) ? ST_DONE : ST_ERROR;
        end
        ST_DONE:  w_next = ST_DONE;
        ST_ERROR: w_next = ST_ERROR;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  // Datapath: header, checksum, write port and registered status outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_len        <= '0;
      r_wcnt       <= '0;
      r_csum       <= '0;
      r_next_addr  <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_core_rst_n <= 1'b0;
    end else begin
      r_we         <= 1'b0;
      r_done       <= (w_next == ST_DONE);
      r_error      <= (w_next == ST_ERROR);
      r_core_rst_n <= (w_next == ST_DONE);
      if (i_start) begin
        r_len       <= '0;
        r_wcnt      <= '0;
        r_csum      <= '0;
        r_next_addr <= '0;
        r_addr      <= '0;
      end else if (w_hs) begin
        case (r_state)
          ST_LEN0: r_len[7:0]  <= i_s_data;
          ST_LEN1: r_len[15:8] <= i_s_data;
          ST_DATA: begin
            r_csum <= r_csum ^ i_s_data;
            if (w_word_valid) begin
              r_wdata     <= w_word;
              r_addr      <= r_next_addr;
              r_next_addr <= r_next_addr + ADDR_W'(4);
              r_we        <= 1'b1;
              r_wcnt      <= r_wcnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_s_ready    = w_ready;
  assign o_prog_we    = r_we;
  assign o_prog_addr  = r_addr;
  assign o_prog_wdata = r_wdata;
  assign o_core_rst_n = r_core_rst_n;
  assign o_done       = r_done;
  assign o_error      = r_error;

endmodule
